countdown_multi: RTL and testbench
==================================

// Module: countdown_multi
// PURPOSE
//  N_CH independent HH:MM:SS BCD countdown timers in the CLK_50 domain.
//  Each channel's 1 s tick comes from an internal prescaler, not from a second clock.
//  One control port addresses a single channel at a time, and a BCD display port shows the selected channel.
//  A per-channel alarm vector drives the top-level buzzer/LED logic.
// PARAMETERS
//  N_CH      4           number of timer channels (1..16)
//  CH_W      2           width of ch_sel; 2**CH_W >= N_CH
//  TICK_DIV  50_000_000  CLK_50 cycles per 1 s tick (>=2; bench uses 4)
//  MAX_HR    9           max hours value, single BCD digit (1..9)
// PORTS
//  CLK_50      in   1      system clock, 50 MHz
//  hard_reset  in   1      asynchronous, active-high reset
//  ch_sel      in   CH_W   channel addressed by controls and display; values >= N_CH ignored
//  adjust      in   1      1-cycle pulse: arm / abort (see FSM)
//  toggle      in   1      1-cycle pulse: field increment / start / pause
//  field       in   2      SETUP increment target: 0=sec 1=min 2=hr 3=none
//  ack         in   1      1-cycle pulse: acknowledge alarm
//  tick_1s     out  1      1-cycle strobe, prescaler wrap
//  disp_h0,disp_m1,disp_m0,disp_s1,disp_s0  out 4 each   BCD digits of selected channel
//  disp_state  out  3      FSM state of selected channel
//  running     out  N_CH   bit i = channel i in RUN
//  alarm       out  N_CH   bit i = channel i in ALARM
// BEHAVIOUR
//  Reset: all channel states SETUP; presets and counts 00:00:00; prescaler 0;
//   all outputs 0 (disp_state=SETUP=0).
//  Prescaler: counts 0..TICK_DIV-1.
//   - tick_1s is high for the cycle in which the count equals TICK_DIV-1.
//   - Free-running, never gated by channel state.
//  FSM per channel: SETUP=0, ARMED=1, RUN=2, PAUSED=3, ALARM=4.
//   Controls act only on channel ch_sel.
//  - SETUP:
//    - toggle increments the preset field chosen by field.
//    - sec and min wrap 59->00 with no carry; hr wraps MAX_HR->0; field=3 is a no-op.
//    - adjust: count<=preset, ->ARMED.
//  - ARMED:
//    - toggle with count!=0 ->RUN; toggle with count==0 is ignored.
//    - adjust ->SETUP.
//  - RUN:
//    - tick_1s decrements the count using a BCD borrow chain: S0 9..0, S1 5..0, M0 9..0, M1 5..0, H0.
//    - If a decrement results in 00:00:00, ->ALARM on the same edge.
//    - toggle ->PAUSED; adjust ->SETUP (count discarded, preset kept).
//  - PAUSED:
//    - Count is frozen; toggle ->RUN; adjust ->SETUP.
//  - ALARM:
//    - Count holds 0.
//    - ack, toggle or adjust: count<=preset, ->ARMED.
//  Priority within one cycle on one channel:
//   - adjust > toggle > ack > tick.
//   - A toggle or adjust coinciding with a tick suppresses that channel's decrement.
//   - Unselected RUN channels still decrement on the tick.
//  Outputs:
//   - All outputs are registered; disp_*, disp_state, running and alarm lag the state/count by 1 cycle.
//   - Display shows the preset in SETUP and the count in every other state.
//   - A ch_sel change is visible on disp_* on the next cycle.
//   - If ch_sel >= N_CH, disp_* and disp_state hold their last values and all control pulses are dropped.
//  Reset mid-run: all channels return to SETUP immediately (async), and presets clear.
// TESTING (TICK_DIV=4, N_CH=4, MAX_HR=9)
//  1. Reset, then observe tick_1s -> strobe every 4th cycle; all outputs 0.
//  2. Ch0 setup:
//     - stimulus: field=1 toggle x3, field=0 toggle x5, adjust, toggle.
//     - response: disp 0:03:05 -> RUN; after 185 ticks alarm[0]=1, disp 0:00:00.
//  3. Borrow and wrap:
//     - stimulus: preset 1:00:00 running.
//     - response: next tick -> 0:59:59; sec toggle x60 in SETUP -> wraps to 00.
//  4. Pause/abort:
//     - stimulus: toggle coinciding with a tick.
//     - response: PAUSED, count unchanged; adjust -> SETUP, preset kept.
//  5. Multichannel:
//     - stimulus: ch1 and ch2 running with presets 0:00:02 and 0:00:03; select ch3.
//     - response: alarm=4'b0010 after 2 ticks, then 4'b0110 after 3 ticks; ack on ch1 -> ARMED, count 0:00:02.
//  6. Reset mid-run:
//     - stimulus: hard_reset asserted mid-cycle.
//     - response: running=0 and alarm=0 asynchronously; presets read 0:00:00; toggle in ARMED with count 0 ignored.

Source files
------------

// File: rtl/countdown_multi_if.sv
// Control and display bundle for the multi-channel countdown timer.
// The master side drives channel selection and control pulses.
// The slave side (the timer) returns the tick strobe, the display of the
// selected channel and the per-channel status vectors.
interface countdown_multi_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic [CH_W-1:0] ch_sel;
    logic            adjust;
    logic            toggle;
    logic [1:0]      field;
    logic            ack;
    logic            tick_1s;
    logic [3:0]      disp_h0;
    logic [3:0]      disp_m1;
    logic [3:0]      disp_m0;
    logic [3:0]      disp_s1;
    logic [3:0]      disp_s0;
    logic [2:0]      disp_state;
    logic [N_CH-1:0] running;
    logic [N_CH-1:0] alarm;

    modport master (
        output ch_sel, adjust, toggle, field, ack,
        input  tick_1s, disp_h0, disp_m1, disp_m0, disp_s1, disp_s0,
        input  disp_state, running, alarm
    );

    modport slave (
        input  ch_sel, adjust, toggle, field, ack,
        output tick_1s, disp_h0, disp_m1, disp_m0, disp_s1, disp_s0,
        output disp_state, running, alarm
    );
endinterface

// File: rtl/countdown_multi.sv
// N_CH independent H:MM:SS BCD countdown timers sharing one 1 s prescaler.
// A single control port addresses the channel chosen by ch_sel; the display
// shows that channel's preset while in SETUP and its live count otherwise.
module countdown_multi #(
    parameter int N_CH     = 4,
    parameter int CH_W     = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_HR   = 9
) (
    input  logic             CLK_50,
    input  logic             hard_reset,
    countdown_multi_if.slave bus
);

    typedef enum logic [2:0] {
        SETUP  = 3'd0,
        ARMED  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        ALARM  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_BEFORE_LAST = PRE_W'(TICK_DIV - 2);

    logic [PRE_W-1:0] presc;
    logic             tick_q;

    state_t    state       [N_CH];
    state_t    state_next  [N_CH];
    bcd_time_t preset      [N_CH];
    bcd_time_t preset_next [N_CH];
    bcd_time_t count       [N_CH];
    bcd_time_t count_next  [N_CH];

    logic            sel_valid;
    logic [N_CH-1:0] sel_hit;
    state_t          shown_state;
    bcd_time_t       shown_time;

    bcd_time_t       disp_time_q;
    state_t          disp_state_q;
    logic [N_CH-1:0] running_q;
    logic [N_CH-1:0] alarm_q;

    // Setup increment: sec/min wrap 59->00 without carry, hours wrap MAX_HR->0.
    function automatic bcd_time_t bump_field(bcd_time_t t, logic [1:0] f);
        bcd_time_t r;
        r = t;
        case (f)
            2'd0: begin
                if (t.s0 == 4'd9) begin
                    r.s0 = 4'd0;
                    r.s1 = (t.s1 == 4'd5) ? 4'd0 : t.s1 + 4'd1;
                end else begin
                    r.s0 = t.s0 + 4'd1;
                end
            end
            2'd1: begin
                if (t.m0 == 4'd9) begin
                    r.m0 = 4'd0;
                    r.m1 = (t.m1 == 4'd5) ? 4'd0 : t.m1 + 4'd1;
                end else begin
                    r.m0 = t.m0 + 4'd1;
                end
            end
            2'd2: r.h0 = (t.h0 == 4'(MAX_HR)) ? 4'd0 : t.h0 + 4'd1;
            default: r = t;
        endcase
        return r;
    endfunction

    // One-second BCD borrow chain; only ever called with a nonzero count.
    function automatic bcd_time_t dec_time(bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'd0) begin
            r.s0 = t.s0 - 4'd1;
        end else begin
            r.s0 = 4'd9;
            if (t.s1 != 4'd0) begin
                r.s1 = t.s1 - 4'd1;
            end else begin
                r.s1 = 4'd5;
                if (t.m0 != 4'd0) begin
                    r.m0 = t.m0 - 4'd1;
                end else begin
                    r.m0 = 4'd9;
                    if (t.m1 != 4'd0) begin
                        r.m1 = t.m1 - 4'd1;
                    end else begin
                        r.m1 = 4'd5;
                        r.h0 = t.h0 - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    // Free-running prescaler; the strobe is registered one count early so it
    // lines up exactly with the cycle where the counter sits at TICK_DIV-1.
    always_ff @(posedge CLK_50 or posedge hard_reset) begin
        if (hard_reset) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= tick_q ? '0 : presc + PRE_W'(1);
            tick_q <= (presc == PRE_BEFORE_LAST);
        end
    end

    // Decode which channel the control port addresses; out-of-range selects hit nothing.
    always_comb begin
        sel_valid = (int'(bus.ch_sel) < N_CH);
        for (int i = 0; i < N_CH; i++) begin
            sel_hit[i] = sel_valid && (bus.ch_sel == CH_W'(i));
        end
    end

    // Per-channel next state, preset and count with adjust > toggle > ack > tick.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_next[i]  = state[i];
            preset_next[i] = preset[i];
            count_next[i]  = count[i];
            case (state[i])
                SETUP: begin
                    if (sel_hit[i] && bus.adjust) begin
                        count_next[i] = preset[i];
                        state_next[i] = ARMED;
                    end else if (sel_hit[i] && bus.toggle) begin
                        preset_next[i] = bump_field(preset[i], bus.field);
                    end
                end
                ARMED: begin
                    if (sel_hit[i] && bus.adjust) begin
                        state_next[i] = SETUP;
                    end else if (sel_hit[i] && bus.toggle && (count[i] != '0)) begin
                        state_next[i] = RUN;
                    end
                end
                RUN: begin
                    if (sel_hit[i] && bus.adjust) begin
                        state_next[i] = SETUP;
                    end else if (sel_hit[i] && bus.toggle) begin
                        state_next[i] = PAUSED;
                    end else if (tick_q) begin
                        count_next[i] = dec_time(count[i]);
                        if (count_next[i] == '0) begin
                            state_next[i] = ALARM;
                        end
                    end
                end
                PAUSED: begin
                    if (sel_hit[i] && bus.adjust) begin
                        state_next[i] = SETUP;
                    end else if (sel_hit[i] && bus.toggle) begin
                        state_next[i] = RUN;
                    end
                end
                ALARM: begin
                    if (sel_hit[i] && (bus.adjust || bus.toggle || bus.ack)) begin
                        count_next[i] = preset[i];
                        state_next[i] = ARMED;
                    end
                end
                default: state_next[i] = SETUP;
            endcase
        end
    end

    // Channel state, preset and count registers.
    always_ff @(posedge CLK_50 or posedge hard_reset) begin
        if (hard_reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i]  <= SETUP;
                preset[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i]  <= state_next[i];
                preset[i] <= preset_next[i];
                count[i]  <= count_next[i];
            end
        end
    end

    // Pick the selected channel's state and the value it should display.
    always_comb begin
        shown_state = SETUP;
        shown_time  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_hit[i]) begin
                shown_state = state[i];
                shown_time  = (state[i] == SETUP) ? preset[i] : count[i];
            end
        end
    end

    // Registered outputs; the display freezes while ch_sel is out of range.
    always_ff @(posedge CLK_50 or posedge hard_reset) begin
        if (hard_reset) begin
            disp_time_q  <= '0;
            disp_state_q <= SETUP;
            running_q    <= '0;
            alarm_q      <= '0;
        end else begin
            if (sel_valid) begin
                disp_time_q  <= shown_time;
                disp_state_q <= shown_state;
            end
            for (int i = 0; i < N_CH; i++) begin
                running_q[i] <= (state[i] == RUN);
                alarm_q[i]   <= (state[i] == ALARM);
            end
        end
    end

    assign bus.tick_1s    = tick_q;
    assign bus.disp_h0    = disp_time_q.h0;
    assign bus.disp_m1    = disp_time_q.m1;
    assign bus.disp_m0    = disp_time_q.m0;
    assign bus.disp_s1    = disp_time_q.s1;
    assign bus.disp_s0    = disp_time_q.s0;
    assign bus.disp_state = disp_state_q;
    assign bus.running    = running_q;
    assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_multi.sv
// Directed bench for countdown_multi with a 4-cycle tick (TICK_DIV=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_countdown_multi;

    logic clk;
    logic hard_reset;
    int   checks;
    int   failures;
    int   n_ticks;

    countdown_multi_if #(.N_CH(4), .CH_W(2)) bus_if ();

    countdown_multi #(
        .N_CH(4),
        .CH_W(2),
        .TICK_DIV(4),
        .MAX_HR(9)
    ) dut (
        .CLK_50(clk),
        .hard_reset(hard_reset),
        .bus(bus_if)
    );

    // 100 MHz simulation clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait loop is broken beyond its own bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkDisp(input string tag, input logic [19:0] expected);
        checkOutput(tag, {12'd0, bus_if.disp_h0, bus_if.disp_m1, bus_if.disp_m0,
                          bus_if.disp_s1, bus_if.disp_s0}, {12'd0, expected});
    endtask

    // One-cycle control pulse on the given channel, starting at a falling edge
    task automatic applyStimulus(input logic [1:0] ch, input logic adj, input logic tog,
                                 input logic ak, input logic [1:0] fld);
        bus_if.ch_sel = ch;
        bus_if.adjust = adj;
        bus_if.toggle = tog;
        bus_if.ack    = ak;
        bus_if.field  = fld;
        @(negedge clk);
        bus_if.adjust = 1'b0;
        bus_if.toggle = 1'b0;
        bus_if.ack    = 1'b0;
        bus_if.field  = 2'd0;
    endtask

    task automatic toggleN(input logic [1:0] ch, input logic [1:0] fld, input int n);
        for (int k = 0; k < n; k++) applyStimulus(ch, 1'b0, 1'b1, 1'b0, fld);
    endtask

    // Stop at the first falling edge (current one included) where tick_1s is high
    task automatic waitTickEdge();
        int guard;
        guard = 0;
        while (!bus_if.tick_1s && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("tick_wait", 32'(bus_if.tick_1s), 32'd1);
    endtask

    // Let n ticks pass, then wait until their effect reaches the outputs
    task automatic waitTicks(input int n);
        for (int k = 0; k < n; k++) begin
            waitTickEdge();
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        hard_reset    = 1'b1;
        bus_if.ch_sel = 2'd0;
        bus_if.adjust = 1'b0;
        bus_if.toggle = 1'b0;
        bus_if.ack    = 1'b0;
        bus_if.field  = 2'd0;

        // 1. reset values and tick cadence
        @(negedge clk);
        @(negedge clk);
        hard_reset = 1'b0;
        checkDisp("reset_disp", 20'h00000);
        checkOutput("reset_state", 32'(bus_if.disp_state), 32'd0);
        checkOutput("reset_running", 32'(bus_if.running), 32'd0);
        checkOutput("reset_alarm", 32'(bus_if.alarm), 32'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("tick_cadence", 32'(bus_if.tick_1s), 32'((k % 4) == 3));
            @(negedge clk);
        end

        // 2. ch0 preset 0:03:05, run to alarm
        toggleN(2'd0, 2'd1, 3);
        toggleN(2'd0, 2'd0, 5);
        @(negedge clk);
        checkDisp("ch0_preset", 20'h00305);
        checkOutput("ch0_setup_state", 32'(bus_if.disp_state), 32'd0);
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("ch0_armed_state", 32'(bus_if.disp_state), 32'd1);
        checkDisp("ch0_armed_disp", 20'h00305);
        applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        n_ticks = bus_if.tick_1s ? 1 : 0;
        @(negedge clk);
        checkOutput("ch0_run_state", 32'(bus_if.disp_state), 32'd2);
        checkOutput("ch0_running", 32'(bus_if.running), 32'b0001);
        for (int g = 0; g < 1200; g++) begin
            if (bus_if.alarm[0]) break;
            if (bus_if.tick_1s) n_ticks++;
            @(negedge clk);
        end
        checkOutput("ch0_alarm", 32'(bus_if.alarm), 32'b0001);
        checkOutput("ch0_ticks_to_alarm", 32'(n_ticks), 32'd185);
        checkDisp("ch0_alarm_disp", 20'h00000);
        checkOutput("ch0_alarm_state", 32'(bus_if.disp_state), 32'd4);
        checkOutput("ch0_alarm_running", 32'(bus_if.running), 32'd0);
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        checkOutput("ch0_ack_state", 32'(bus_if.disp_state), 32'd1);
        checkDisp("ch0_ack_reload", 20'h00305);
        checkOutput("ch0_ack_alarm", 32'(bus_if.alarm), 32'd0);

        // 3a. ch3 preset 1:00:00, first tick borrows to 0:59:59
        applyStimulus(2'd3, 1'b0, 1'b1, 1'b0, 2'd2);
        @(negedge clk);
        checkDisp("ch3_preset_hr", 20'h10000);
        applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(2'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        waitTicks(1);
        checkDisp("ch3_borrow", 20'h05959);
        checkOutput("ch3_run_state", 32'(bus_if.disp_state), 32'd2);

        // 4. toggle on a tick pauses without decrementing; adjust keeps preset
        waitTickEdge();
        applyStimulus(2'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("ch3_paused_state", 32'(bus_if.disp_state), 32'd3);
        checkDisp("ch3_pause_no_dec", 20'h05959);
        repeat (8) @(negedge clk);
        checkDisp("ch3_pause_frozen", 20'h05959);
        applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("ch3_abort_state", 32'(bus_if.disp_state), 32'd0);
        checkDisp("ch3_abort_preset", 20'h10000);

        // 3b. seconds and hours wrap in SETUP; field 3 is a no-op
        toggleN(2'd3, 2'd0, 59);
        @(negedge clk);
        checkDisp("ch3_sec_59", 20'h10059);
        toggleN(2'd3, 2'd0, 1);
        @(negedge clk);
        checkDisp("ch3_sec_wrap", 20'h10000);
        toggleN(2'd3, 2'd3, 2);
        @(negedge clk);
        checkDisp("ch3_field_none", 20'h10000);
        toggleN(2'd3, 2'd2, 8);
        @(negedge clk);
        checkDisp("ch3_hr_max", 20'h90000);
        toggleN(2'd3, 2'd2, 1);
        @(negedge clk);
        checkDisp("ch3_hr_wrap", 20'h00000);

        // 5. ch1 (0:00:02) and ch2 (0:00:03) running while ch3 is displayed
        toggleN(2'd1, 2'd0, 2);
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        toggleN(2'd2, 2'd0, 3);
        applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        waitTickEdge();
        @(negedge clk);
        applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(2'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        bus_if.ch_sel = 2'd3;
        waitTicks(2);
        checkOutput("multi_alarm_2", 32'(bus_if.alarm), 32'b0010);
        checkOutput("multi_running_2", 32'(bus_if.running), 32'b0100);
        checkOutput("multi_ch3_state", 32'(bus_if.disp_state), 32'd0);
        waitTicks(1);
        checkOutput("multi_alarm_3", 32'(bus_if.alarm), 32'b0110);
        checkOutput("multi_running_3", 32'(bus_if.running), 32'b0000);
        applyStimulus(2'd1, 1'b0, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        checkOutput("ch1_ack_state", 32'(bus_if.disp_state), 32'd1);
        checkDisp("ch1_ack_reload", 20'h00002);
        checkOutput("ch1_ack_alarm", 32'(bus_if.alarm), 32'b0100);

        // 6. asynchronous reset in the middle of a cycle
        applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("pre_reset_running", 32'(bus_if.running), 32'b0010);
        #3 hard_reset = 1'b1;
        #1;
        checkOutput("async_running", 32'(bus_if.running), 32'd0);
        checkOutput("async_alarm", 32'(bus_if.alarm), 32'd0);
        checkOutput("async_state", 32'(bus_if.disp_state), 32'd0);
        @(negedge clk);
        hard_reset = 1'b0;
        @(negedge clk);
        checkDisp("post_reset_preset", 20'h00000);
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        checkOutput("zero_toggle_state", 32'(bus_if.disp_state), 32'd1);
        checkOutput("zero_toggle_running", 32'(bus_if.running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
